// File: rtl/semester_tracker.sv
`default_nettype none
// ============================================================================
// Module      : semester_tracker
// Description : Per-semester daily result tracker with probation and grading.
// Revision    : 1.0 - initial release
// ============================================================================
module semester_tracker #(
    parameter int SEM_DAYS   = 16,
    parameter int FAIL_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       day_valid,
    input  logic       pass3,
    input  logic [1:0] bonus2,
    output logic       day_ready,
    output logic [4:0] pass_cnt,
    output logic [6:0] credit,
    output logic       probation,
    output logic       done,
    output logic [1:0] grade
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_active = 2'd1;
    localparam logic [1:0] c_st_prob   = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [4:0] c_sem_days   = 5'(SEM_DAYS);
    localparam logic [6:0] c_sem_credit = 7'(SEM_DAYS);
    localparam logic [7:0] c_sem_x1     = 8'(SEM_DAYS);
    localparam logic [7:0] c_sem_x3     = 8'(3 * SEM_DAYS);
    localparam logic [2:0] c_fail_limit = 3'(FAIL_LIMIT);

    logic [1:0] r_state;
    logic [4:0] r_day_cnt;
    logic [2:0] r_fail_streak;
    logic [1:0] r_pass_streak;

    logic [1:0] w_state_nxt;
    logic [4:0] w_day_cnt_nxt;
    logic [4:0] w_pass_cnt_nxt;
    logic [6:0] w_credit_nxt;
    logic [2:0] w_fail_nxt;
    logic [1:0] w_pstreak_nxt;
    logic [1:0] w_grade_nxt;
    logic       w_ready_nxt;
    logic       w_prob_nxt;
    logic       w_done_nxt;

    logic       w_accept;
    logic [4:0] w_day_upd;
    logic [4:0] w_pass_upd;
    logic [6:0] w_credit_upd;
    logic [7:0] w_credit_sum;
    logic [2:0] w_fail_upd;
    logic [1:0] w_pstreak_upd;
    logic [7:0] w_p_x4;
    logic [7:0] w_p_x2;
    logic [1:0] w_final_grade;

    // Counter/streak values as they would be after accepting the current day
    assign w_accept      = day_valid & day_ready;
    assign w_day_upd     = r_day_cnt + 5'd1;
    assign w_credit_sum  = {1'b0, credit} + {6'd0, bonus2};
    assign w_pass_upd    = pass3 ? (pass_cnt + 5'd1) : pass_cnt;
    assign w_credit_upd  = !pass3 ? credit : (w_credit_sum[7] ? 7'h7f : w_credit_sum[6:0]);
    assign w_fail_upd    = pass3 ? 3'd0 : ((r_fail_streak == 3'd7) ? 3'd7 : r_fail_streak + 3'd1);
    assign w_pstreak_upd = !pass3 ? 2'd0 : ((r_pass_streak == 2'd3) ? 2'd3 : r_pass_streak + 2'd1);

    assign w_p_x4 = {1'b0, w_pass_upd, 2'b00};
    assign w_p_x2 = {2'b00, w_pass_upd, 1'b0};

    always_comb begin
        if ((w_pass_upd == c_sem_days) && (w_credit_upd >= c_sem_credit)) begin
            w_final_grade = 2'd3;
        end else if (w_p_x4 >= c_sem_x3) begin
            w_final_grade = 2'd2;
        end else if (w_p_x2 >= c_sem_x1) begin
            w_final_grade = 2'd1;
        end else begin
            w_final_grade = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_day_cnt     <= 5'd0;
            r_fail_streak <= 3'd0;
            r_pass_streak <= 2'd0;
            pass_cnt      <= 5'd0;
            credit        <= 7'd0;
            grade         <= 2'd0;
            day_ready     <= 1'b0;
            probation     <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_day_cnt     <= w_day_cnt_nxt;
            r_fail_streak <= w_fail_nxt;
            r_pass_streak <= w_pstreak_nxt;
            pass_cnt      <= w_pass_cnt_nxt;
            credit        <= w_credit_nxt;
            grade         <= w_grade_nxt;
            day_ready     <= w_ready_nxt;
            probation     <= w_prob_nxt;
            done          <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_day_cnt_nxt  = r_day_cnt;
        w_pass_cnt_nxt = pass_cnt;
        w_credit_nxt   = credit;
        w_fail_nxt     = r_fail_streak;
        w_pstreak_nxt  = r_pass_streak;
        w_grade_nxt    = grade;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt    = c_st_active;
                    w_day_cnt_nxt  = 5'd0;
                    w_pass_cnt_nxt = 5'd0;
                    w_credit_nxt   = 7'd0;
                    w_fail_nxt     = 3'd0;
                    w_pstreak_nxt  = 2'd0;
                    w_grade_nxt    = 2'd0;
                end
            end
            c_st_active, c_st_prob: begin
                if (w_accept) begin
                    w_day_cnt_nxt  = w_day_upd;
                    w_pass_cnt_nxt = w_pass_upd;
                    w_credit_nxt   = w_credit_upd;
                    w_fail_nxt     = w_fail_upd;
                    w_pstreak_nxt  = w_pstreak_upd;
                    // A fail during probation ends the semester before the day-count check
                    if ((r_state == c_st_prob) && !pass3) begin
                        w_state_nxt = c_st_done;
                        w_grade_nxt = 2'd0;
                    end else if (w_day_upd == c_sem_days) begin
                        w_state_nxt = c_st_done;
                        w_grade_nxt = w_final_grade;
                    end else if ((r_state == c_st_active) && (w_fail_upd == c_fail_limit)) begin
                        w_state_nxt = c_st_prob;
                    end else if ((r_state == c_st_prob) && (w_pstreak_upd == 2'd2)) begin
                        w_state_nxt = c_st_active;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == c_st_active) || (w_state_nxt == c_st_prob);
        w_prob_nxt  = (w_state_nxt == c_st_prob);
        w_done_nxt  = (w_state_nxt == c_st_done);
    end

endmodule
`default_nettype wire

// File: tb/tb_semester_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_semester_tracker
// Description : Directed self-checking bench for semester_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semester_tracker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       day_valid;
    logic       pass3;
    logic [1:0] bonus2;

    logic       day_ready;
    logic [4:0] pass_cnt;
    logic [6:0] credit;
    logic       probation;
    logic       done;
    logic [1:0] grade;

    logic       day_ready_31;
    logic [4:0] pass_cnt_31;
    logic [6:0] credit_31;
    logic       probation_31;
    logic       done_31;
    logic [1:0] grade_31;

    int n_checks;
    int n_errors;

    semester_tracker u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .day_valid (day_valid),
        .pass3     (pass3),
        .bonus2    (bonus2),
        .day_ready (day_ready),
        .pass_cnt  (pass_cnt),
        .credit    (credit),
        .probation (probation),
        .done      (done),
        .grade     (grade)
    );

    semester_tracker #(.SEM_DAYS(31), .FAIL_LIMIT(3)) u_dut31 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .day_valid (day_valid),
        .pass3     (pass3),
        .bonus2    (bonus2),
        .day_ready (day_ready_31),
        .pass_cnt  (pass_cnt_31),
        .credit    (credit_31),
        .probation (probation_31),
        .done      (done_31),
        .grade     (grade_31)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge
    task automatic do_day(input logic p, input logic [1:0] b);
        day_valid = 1'b1;
        pass3     = p;
        bonus2    = b;
        @(negedge clk);
        day_valid = 1'b0;
    endtask

    task automatic run_days(input logic [31:0] pat, input int n, input logic [1:0] b);
        for (int i = 0; i < n; i++) do_day(pat[i], b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        day_valid = 1'b0;
        pass3     = 1'b0;
        bonus2    = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_ready", day_ready, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_credit", credit, 0);
        check("rst_prob", probation, 0);
        check("rst_done", done, 0);
        check("rst_grade", grade, 0);

        // Idle ignores day_valid
        day_valid = 1'b1; pass3 = 1'b1; bonus2 = 2'd3;
        repeat (3) @(negedge clk);
        day_valid = 1'b0;
        check("idle_pass", pass_cnt, 0);
        check("idle_credit", credit, 0);
        check("idle_ready", day_ready, 0);

        // Perfect semester
        pulse_start();
        check("p16_ready", day_ready, 1);
        run_days(32'hFFFF_FFFF, 15, 2'd1);
        check("p16_done15", done, 0);
        do_day(1'b1, 2'd1);
        check("p16_done", done, 1);
        check("p16_pass", pass_cnt, 16);
        check("p16_credit", credit, 16);
        check("p16_grade", grade, 3);
        check("p16_ready_off", day_ready, 0);

        day_valid = 1'b1; pass3 = 1'b1; bonus2 = 2'd3;
        repeat (3) @(negedge clk);
        day_valid = 1'b0;
        check("done_hold_pass", pass_cnt, 16);
        check("done_hold_credit", credit, 16);
        check("done_hold_done", done, 1);
        check("done_hold_grade", grade, 3);

        // 12 passes, fails on every 4th day
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            do_day((i % 4) != 3, 2'd0);
            check("g2_no_prob", probation, 0);
        end
        check("g2_done", done, 1);
        check("g2_pass", pass_cnt, 12);
        check("g2_credit", credit, 0);
        check("g2_grade", grade, 2);

        // PPFF x4: 8 passes
        pulse_start();
        run_days(32'h0000_3333, 16, 2'd1);
        check("g1_done", done, 1);
        check("g1_pass", pass_cnt, 8);
        check("g1_credit", credit, 8);
        check("g1_grade", grade, 1);

        // PFF x5 + P: 6 passes
        pulse_start();
        run_days(32'h0000_9249, 16, 2'd0);
        check("g0_done", done, 1);
        check("g0_pass", pass_cnt, 6);
        check("g0_grade", grade, 0);
        check("g0_prob", probation, 0);

        // Probation then failure
        pulse_start();
        run_days(32'h0, 2, 2'd0);
        check("pr_prob2", probation, 0);
        do_day(1'b0, 2'd0);
        check("pr_prob3", probation, 1);
        check("pr_ready3", day_ready, 1);
        do_day(1'b0, 2'd0);
        check("pr_done", done, 1);
        check("pr_grade", grade, 0);
        check("pr_prob_off", probation, 0);
        check("pr_ready_off", day_ready, 0);

        // Probation recovery
        pulse_start();
        run_days(32'h0, 3, 2'd0);
        check("rc_prob", probation, 1);
        do_day(1'b1, 2'd2);
        check("rc_prob_p1", probation, 1);
        do_day(1'b1, 2'd2);
        check("rc_prob_p2", probation, 0);
        check("rc_ready", day_ready, 1);
        do_day(1'b0, 2'd0);
        check("rc_prob_f1", probation, 0);
        check("rc_done_f1", done, 0);
        run_days(32'h0, 2, 2'd0);
        check("rc_prob_again", probation, 1);
        check("rc_pass", pass_cnt, 2);
        check("rc_credit", credit, 4);

        // Start ignored mid-semester
        pulse_start();
        check("ms_prob", probation, 1);
        check("ms_pass", pass_cnt, 2);
        check("ms_credit", credit, 4);
        check("ms_done", done, 0);

        // Asynchronous reset at day 7
        do_reset();
        pulse_start();
        run_days(32'hFFFF_FFFF, 6, 2'd2);
        check("ar_pass6", pass_cnt, 6);
        check("ar_credit6", credit, 12);
        day_valid = 1'b1; pass3 = 1'b1; bonus2 = 2'd2;
        #2 rst_n = 1'b0;
        #1;
        check("ar_ready", day_ready, 0);
        check("ar_pass", pass_cnt, 0);
        check("ar_credit", credit, 0);
        check("ar_prob", probation, 0);
        check("ar_done", done, 0);
        check("ar_grade", grade, 0);
        @(negedge clk);
        day_valid = 1'b0;
        rst_n     = 1'b1;
        check("ar_idle", day_ready, 0);
        pulse_start();
        do_day(1'b1, 2'd3);
        check("ar_pass1", pass_cnt, 1);
        check("ar_credit1", credit, 3);
        run_days(32'hFFFF_FFFF, 14, 2'd0);
        check("ar_done15", done, 0);
        do_day(1'b1, 2'd0);
        check("ar_done16", done, 1);
        check("ar_pass16", pass_cnt, 16);
        check("ar_grade16", grade, 2);

        // 31-day semester with maximal bonus
        do_reset();
        pulse_start();
        for (int i = 0; i < 31; i++) begin
            do_day(1'b1, 2'd3);
            if (i == 29) check("s31_done30", done_31, 0);
        end
        check("s31_done", done_31, 1);
        check("s31_pass", pass_cnt_31, 31);
        check("s31_credit", credit_31, 93);
        check("s31_grade", grade_31, 3);
        check("s16_pass", pass_cnt, 16);
        check("s16_credit", credit, 48);
        check("s16_grade", grade, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/semester_tracker.md
SEMESTER_TRACKER -- requirements
Module: semester_tracker

Interface
REQ-001 Parameter SEM_DAYS, default 16, number of daily results per semester (legal range 2..31).
REQ-002 Parameter FAIL_LIMIT, default 3, consecutive failing days that enter probation (legal range 1..7).
REQ-003 clk  input  1  rising-edge clock; one clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a semester.
REQ-006 day_valid  input  1  daily result present on pass3/bonus2.
REQ-007 pass3  input  1  daily pass flag from the stage3 output of the daily-commute chain.
REQ-008 bonus2  input  2  daily bonus from stage2, range 0..3.
REQ-009 day_ready  output  1  tracker accepts a result this cycle.
REQ-010 pass_cnt  output  5  passing days accepted this semester.
REQ-011 credit  output  7  accumulated bonus credit.
REQ-012 probation  output  1  high while in PROBATION.
REQ-013 done  output  1  semester finished; held until the next start.
REQ-014 grade  output  2  final grade; valid only while done=1.

Function
REQ-015 The block SHALL implement states IDLE, ACTIVE, PROBATION, DONE; every output SHALL be registered.
REQ-016 day_ready SHALL be 1 exactly in ACTIVE and PROBATION; a result is accepted on a rising edge where day_valid=1 and day_ready=1.
REQ-017 IDLE or DONE with start=1 SHALL go to ACTIVE and clear pass_cnt, credit, day counter, fail streak, pass streak, done, grade, probation.
REQ-018 start in ACTIVE or PROBATION SHALL be ignored.
REQ-019 Each accepted day SHALL increment the internal day counter by 1.
REQ-020 Accepted pass3=1: pass_cnt +1, credit + bonus2 saturating at 127, fail streak cleared, pass streak +1 (saturating at 3).
REQ-021 Accepted pass3=0: fail streak +1 (saturating at 7), pass streak cleared, pass_cnt and credit unchanged.
REQ-022 ACTIVE -> PROBATION when the updated fail streak equals FAIL_LIMIT.
REQ-023 In PROBATION, an accepted pass3=0 SHALL go to DONE with grade=0 regardless of day count.
REQ-024 In PROBATION, the second consecutive accepted pass SHALL return to ACTIVE with fail streak 0.
REQ-025 When the updated day count equals SEM_DAYS and REQ-023 does not apply, the block SHALL go to DONE; grade SHALL then be computed from the updated pass_cnt P and credit C.
REQ-026 At DONE, grade=3 if P = SEM_DAYS and C >= SEM_DAYS, else 2 if 4*P >= 3*SEM_DAYS, else 1 if 2*P >= SEM_DAYS, else 0; widths SHALL be sized so no intermediate overflows.
REQ-027 Any accepted day that reaches SEM_DAYS while in PROBATION SHALL end the semester using REQ-026, unless REQ-023 applies.
REQ-028 done, grade, probation SHALL update on the same edge as the state change (1-cycle latency from acceptance).
REQ-029 day_valid while day_ready=0 SHALL be ignored with no state change.
REQ-030 In DONE the block SHALL hold all outputs stable until start or reset.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, day_ready=0, pass_cnt=0, credit=0, probation=0, done=0, grade=0, and clear all internal counters and streaks.
REQ-032 Reset asserted mid-semester SHALL discard all progress; after release the block waits in IDLE for start.
REQ-033 Reset SHALL be released synchronously to clk by the system; the block needs no internal synchronizer.

Verification
REQ-034 start, then 16 days pass3=1, bonus2=1 -> done=1 after the 16th acceptance, pass_cnt=16, credit=16, grade=3.
REQ-035 start, then 12 passes and 4 non-consecutive fails -> grade=2, pass_cnt=12, probation never 1.
REQ-036 start, then 3 fails -> probation=1 on the edge after the 3rd fail and day_ready stays 1; 1 further fail -> done=1, grade=0, after 4 days.
REQ-037 Probation entered; then 2 passes -> probation=0 back to ACTIVE; a single fail then leaves probation=0 (streak restarted).
REQ-038 day_valid=1 held in IDLE and DONE, and start pulsed mid-semester -> no counter change; rst_n=0 asserted at day 7 -> all outputs 0 immediately, next start begins from day 0.
REQ-039 127 credit saturation: SEM_DAYS=31 override, pass3=1, bonus2=3 every day -> credit reaches 93 without wrap; force-check saturation with a 2-day preset via repeated semesters not required, REQ-020 saturation covered by assertion.
